gmsk_rx: RTL and testbench

Coherence-free GMSK demodulator: the receive-side counterpart of the ROM-based GMSK modulator. It consumes strobed signed I/Q baseband samples and computes a one-sample differential phase discriminator (cross product of consecutive samples). It integrates the discriminator over each symbol period and emits one hard bit decision per symbol, plus the soft metric. It sits between the baseband sample source (ADC/decimator) and the burst/framing logic, and shares the transmit path's sample and symbol strobe scheme.

---
 rtl/gmsk_rx.sv | 173 +++++++++++++++++
 tb/tb_gmsk_rx.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/gmsk_rx.sv
// Differential-phase GMSK demodulator: cross-product discriminator integrated per symbol, one hard bit per symbol.
// Optional build macro GMSK_RX_DIFF_DECODE_EN adds differential decoding of the hard decision.
module gmsk_rx #(
    parameter int BITS_PER_SAMPLE = 8,
    parameter int SAMPLES_PER_SYMBOL = 128,
    localparam int ACC_WIDTH = 2 * BITS_PER_SAMPLE + 1 + $clog2(SAMPLES_PER_SYMBOL)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        sample_strobe,
    input  logic                        symbol_strobe,
    input  logic signed [BITS_PER_SAMPLE-1:0] inphase_in,
    input  logic signed [BITS_PER_SAMPLE-1:0] quadrature_in,
    output logic                        bit_out,
    output logic                        bit_strobe,
    output logic signed [ACC_WIDTH-1:0] metric_out
);
    localparam int B = BITS_PER_SAMPLE;
    localparam int P_W = 2 * B;
    localparam int D_W = 2 * B + 1;
    localparam int IDX_W = $clog2(SAMPLES_PER_SYMBOL);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES_PER_SYMBOL - 1);

    function automatic logic signed [P_W-1:0] widen_smp(input logic signed [B-1:0] x);
        return {{B{x[B-1]}}, x};
    endfunction

    function automatic logic signed [D_W-1:0] widen_prod(input logic signed [P_W-1:0] x);
        return {x[P_W-1], x};
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] widen_disc(input logic signed [D_W-1:0] x);
        return {{(ACC_WIDTH - D_W){x[D_W-1]}}, x};
    endfunction

    logic [IDX_W-1:0]       idx_q, idx_d, sample_idx;
    logic                   realign_q, realign_d;
    logic signed [B-1:0]    cur_inph_p0_q, cur_inph_p0_d, cur_quad_p0_q, cur_quad_p0_d;
    logic signed [B-1:0]    prev_inph_p0_q, prev_inph_p0_d, prev_quad_p0_q, prev_quad_p0_d;
    logic [IDX_W-1:0]       idx_p0_q, idx_p0_d, idx_p1_q, idx_p1_d, idx_p2_q, idx_p2_d;
    logic                   vld_p0_q, vld_p0_d, vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
    logic signed [P_W-1:0]  pa_p1_q, pa_p1_d, pb_p1_q, pb_p1_d;
    logic signed [D_W-1:0]  d_p2_q, d_p2_d;
    logic signed [ACC_WIDTH-1:0] acc_p3_q, acc_p3_d, metric_q, metric_d;
    logic                   bit_q, bit_d, bit_strobe_q, bit_strobe_d, raw;
`ifdef GMSK_RX_DIFF_DECODE_EN
    logic                   last_raw_q, last_raw_d;
`endif

    always_comb begin
        idx_d          = idx_q;
        realign_d      = realign_q;
        cur_inph_p0_d  = cur_inph_p0_q;
        cur_quad_p0_d  = cur_quad_p0_q;
        prev_inph_p0_d = prev_inph_p0_q;
        prev_quad_p0_d = prev_quad_p0_q;
        idx_p0_d       = idx_p0_q;
        pa_p1_d        = pa_p1_q;
        pb_p1_d        = pb_p1_q;
        idx_p1_d       = idx_p1_q;
        d_p2_d         = d_p2_q;
        idx_p2_d       = idx_p2_q;
        acc_p3_d       = acc_p3_q;
        metric_d       = metric_q;
        bit_d          = bit_q;
        bit_strobe_d   = 1'b0;
        raw            = 1'b0;
`ifdef GMSK_RX_DIFF_DECODE_EN
        last_raw_d     = last_raw_q;
`endif
        // A symbol strobe, with or without a sample, forces the next indexed sample to 0.
        sample_idx = (symbol_strobe || realign_q) ? '0 : idx_q;

        // S0: sample register and index tagging
        vld_p0_d = sample_strobe;
        if (sample_strobe) begin
            cur_inph_p0_d  = inphase_in;
            cur_quad_p0_d  = quadrature_in;
            prev_inph_p0_d = cur_inph_p0_q;
            prev_quad_p0_d = cur_quad_p0_q;
            idx_p0_d       = sample_idx;
            idx_d          = sample_idx + IDX_W'(1);
            realign_d      = 1'b0;
        end else if (symbol_strobe) begin
            realign_d = 1'b1;
        end

        // S1: cross products
        vld_p1_d = vld_p0_q;
        if (vld_p0_q) begin
            pa_p1_d  = widen_smp(prev_inph_p0_q) * widen_smp(cur_quad_p0_q);
            pb_p1_d  = widen_smp(prev_quad_p0_q) * widen_smp(cur_inph_p0_q);
            idx_p1_d = idx_p0_q;
        end

        // S2: discriminator
        vld_p2_d = vld_p1_q;
        if (vld_p1_q) begin
            d_p2_d   = widen_prod(pa_p1_q) - widen_prod(pb_p1_q);
            idx_p2_d = idx_p1_q;
        end

        // S3: integrate, and decide on the last sample of the symbol
        if (vld_p2_q) begin
            acc_p3_d = (idx_p2_q == '0) ? widen_disc(d_p2_q) : acc_p3_q + widen_disc(d_p2_q);
            if (idx_p2_q == LAST_IDX) begin
                raw          = acc_p3_d[ACC_WIDTH-1];
                metric_d     = acc_p3_d;
                bit_strobe_d = 1'b1;
`ifdef GMSK_RX_DIFF_DECODE_EN
                bit_d        = raw ^ last_raw_q;
                last_raw_d   = raw;
`else
                bit_d        = raw;
`endif
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx_q          <= '0;
            realign_q      <= 1'b0;
            cur_inph_p0_q  <= '0;
            cur_quad_p0_q  <= '0;
            prev_inph_p0_q <= '0;
            prev_quad_p0_q <= '0;
            idx_p0_q       <= '0;
            vld_p0_q       <= 1'b0;
            pa_p1_q        <= '0;
            pb_p1_q        <= '0;
            idx_p1_q       <= '0;
            vld_p1_q       <= 1'b0;
            d_p2_q         <= '0;
            idx_p2_q       <= '0;
            vld_p2_q       <= 1'b0;
            acc_p3_q       <= '0;
            metric_q       <= '0;
            bit_q          <= 1'b0;
            bit_strobe_q   <= 1'b0;
`ifdef GMSK_RX_DIFF_DECODE_EN
            last_raw_q     <= 1'b0;
`endif
        end else begin
            idx_q          <= idx_d;
            realign_q      <= realign_d;
            cur_inph_p0_q  <= cur_inph_p0_d;
            cur_quad_p0_q  <= cur_quad_p0_d;
            prev_inph_p0_q <= prev_inph_p0_d;
            prev_quad_p0_q <= prev_quad_p0_d;
            idx_p0_q       <= idx_p0_d;
            vld_p0_q       <= vld_p0_d;
            pa_p1_q        <= pa_p1_d;
            pb_p1_q        <= pb_p1_d;
            idx_p1_q       <= idx_p1_d;
            vld_p1_q       <= vld_p1_d;
            d_p2_q         <= d_p2_d;
            idx_p2_q       <= idx_p2_d;
            vld_p2_q       <= vld_p2_d;
            acc_p3_q       <= acc_p3_d;
            metric_q       <= metric_d;
            bit_q          <= bit_d;
            bit_strobe_q   <= bit_strobe_d;
`ifdef GMSK_RX_DIFF_DECODE_EN
            last_raw_q     <= last_raw_d;
`endif
        end
    end

    assign bit_out    = bit_q;
    assign bit_strobe = bit_strobe_q;
    assign metric_out = metric_q;
endmodule

// File: tb/tb_gmsk_rx.sv
// Bench for gmsk_rx at SAMPLES_PER_SYMBOL=4: directed rotation/gap/realign/reset cases plus
// randomized traffic, all checked cycle by cycle against a symbol-level reference model.
module tb_gmsk_rx;
    localparam int SPS = 4;
    localparam int BPS = 8;
    localparam int ACC_W = 2 * BPS + 1 + $clog2(SPS);

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic sample_strobe = 1'b0;
    logic symbol_strobe = 1'b0;
    logic signed [BPS-1:0] inphase_in = '0;
    logic signed [BPS-1:0] quadrature_in = '0;
    logic bit_out;
    logic bit_strobe;
    logic signed [ACC_W-1:0] metric_out;

    gmsk_rx #(.BITS_PER_SAMPLE(BPS), .SAMPLES_PER_SYMBOL(SPS)) dut (
        .clock(clock), .reset(reset), .sample_strobe(sample_strobe),
        .symbol_strobe(symbol_strobe), .inphase_in(inphase_in),
        .quadrature_in(quadrature_in), .bit_out(bit_out),
        .bit_strobe(bit_strobe), .metric_out(metric_out)
    );

    always #5 clock = ~clock;

    typedef struct { int due; int metric; logic bitv; } ev_t;
    ev_t evq[$];
    int  sym_discs[$];
    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  m_pi, m_pq, m_next_idx;
    bit  m_pending, m_last_raw;
    logic hold_bit;
    int  hold_metric;

    int ccw_i[4] = '{100, 0, -100, 0};
    int ccw_q[4] = '{0, 100, 0, -100};
    int cw_q[4]  = '{0, -100, 0, 100};

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_clear();
        evq.delete();
        sym_discs.delete();
        m_pi = 0; m_pq = 0; m_next_idx = 0;
        m_pending = 0; m_last_raw = 0;
        hold_bit = 1'b0; hold_metric = 0;
    endtask

    // Output comparison for the current cycle against the scheduled decisions.
    task automatic check_outputs();
        logic exp_stb;
        exp_stb = 1'b0;
        if (evq.size() > 0 && evq[0].due == cyc) begin
            exp_stb     = 1'b1;
            hold_bit    = evq[0].bitv;
            hold_metric = evq[0].metric;
            void'(evq.pop_front());
        end
        chk("bit_strobe", bit_strobe, exp_stb);
        chk("bit_out", bit_out, hold_bit);
        chk("metric_out", metric_out, hold_metric);
    endtask

    task automatic step(input logic ss, input logic sym, input int i, input int q);
        int idx, disc, sum;
        logic raw, b;
        reset = 1'b0;
        sample_strobe = ss;
        symbol_strobe = sym;
        inphase_in = BPS'(i);
        quadrature_in = BPS'(q);
        @(posedge clock);
        if (ss) begin
            idx = (sym || m_pending) ? 0 : m_next_idx;
            m_pending = 0;
            disc = m_pi * q - m_pq * i;
            m_pi = i; m_pq = q;
            if (idx == 0) sym_discs.delete();
            sym_discs.push_back(disc);
            if (idx == SPS - 1) begin
                sum = 0;
                foreach (sym_discs[k]) sum += sym_discs[k];
                raw = (sum < 0);
`ifdef GMSK_RX_DIFF_DECODE_EN
                b = raw ^ m_last_raw;
                m_last_raw = raw;
`else
                b = raw;
`endif
                evq.push_back('{due: cyc + 3, metric: sum, bitv: b});
            end
            m_next_idx = (idx + 1) % SPS;
        end else if (sym) begin
            m_pending = 1;
        end
        #1;
        check_outputs();
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_strobe = 1'b0;
        symbol_strobe = 1'b0;
        @(posedge clock);
        #1;
        model_clear();
        check_outputs();
        cyc++;
    endtask

    initial begin
        logic exp_bits[4];
        int   exp_metrics[4];
        model_clear();
        do_reset();
        do_reset();
        chk("reset_metric", metric_out, 0);

        // CCW rotation, strobes every cycle
        for (int k = 0; k < 16; k++) begin
            step(1'b1, k == 0, ccw_i[k % 4], ccw_q[k % 4]);
            if (k == 6) begin
                chk("ccw_first_strobe", bit_strobe, 1);
                chk("ccw_first_metric", metric_out, 30000);
                chk("ccw_first_bit", bit_out, 0);
            end
            if (k == 10) chk("ccw_steady_metric", metric_out, 40000);
            if (k == 9) chk("ccw_no_early_strobe", bit_strobe, 0);
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 0);

        // CW rotation
        do_reset();
        for (int k = 0; k < 12; k++) begin
            step(1'b1, k == 0, ccw_i[k % 4], cw_q[k % 4]);
            if (k == 10) begin
                chk("cw_steady_metric", metric_out, -40000);
                chk("cw_steady_bit", bit_out, 1);
            end
        end
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 0, 0);

        // CCW with a sample every third cycle
        do_reset();
        for (int k = 0; k < 27; k++) begin
            step(k % 3 == 0, k == 0, ccw_i[(k / 3) % 4], ccw_q[(k / 3) % 4]);
            if (k == 12) chk("gap_first_metric", metric_out, 30000);
            if (k == 24) begin
                chk("gap_second_strobe", bit_strobe, 1);
                chk("gap_second_metric", metric_out, 40000);
            end
        end

        // Realignment after two samples
        do_reset();
        step(1'b1, 1'b1, 100, 0);
        step(1'b1, 1'b0, 0, 100);
        step(1'b0, 1'b1, 0, 0);
        step(1'b1, 1'b0, -100, 0);
        step(1'b1, 1'b0, 0, -100);
        step(1'b1, 1'b0, 100, 0);
        step(1'b1, 1'b0, 0, 100);
        step(1'b0, 1'b0, 0, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("realign_not_yet", bit_strobe, 0);
        step(1'b0, 1'b0, 0, 0);
        chk("realign_strobe", bit_strobe, 1);
        chk("realign_metric", metric_out, 40000);
        step(1'b0, 1'b0, 0, 0);

        // Reset while a decision is in flight
        do_reset();
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, ccw_i[k % 4], cw_q[k % 4]);
        do_reset();
        chk("rst_mid_bit", bit_out, 0);
        chk("rst_mid_metric", metric_out, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 0, 0);
            chk("rst_mid_no_strobe", bit_strobe, 0);
        end

        // Direction sequence CCW, CW, CW, CCW
`ifdef GMSK_RX_DIFF_DECODE_EN
        exp_bits = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_bits = '{1'b0, 1'b1, 1'b1, 1'b0};
`endif
        exp_metrics = '{30000, -20000, -40000, 20000};
        do_reset();
        for (int n = 0; n < 19; n++) begin
            if (n < 16) begin
                if ((n / 4) == 1 || (n / 4) == 2)
                    step(1'b1, n == 0, ccw_i[n % 4], cw_q[n % 4]);
                else
                    step(1'b1, n == 0, ccw_i[n % 4], ccw_q[n % 4]);
            end else begin
                step(1'b0, 1'b0, 0, 0);
            end
            if (n >= 6 && (n - 6) % 4 == 0) begin
                chk("seq_bit", bit_out, exp_bits[(n - 6) / 4]);
                chk("seq_metric", metric_out, exp_metrics[(n - 6) / 4]);
            end
        end

        // Randomized traffic with gaps and stray symbol strobes
        do_reset();
        for (int k = 0; k < 400; k++)
            step($urandom_range(9) < 7, $urandom_range(19) == 0,
                 int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        for (int k = 0; k < 150; k++)
            step(1'b1, $urandom_range(29) == 0,
                 int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
        for (int k = 0; k < 3; k++)
            step(1'b1, 1'b0, -128, -128);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 0, 0);
        chk("pending_decisions", evq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
